// File: rtl/punc_pkg.sv
// Shared select encodings and opcode constants for the PUnC LC3 datapath and its control FSM.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package punc_pkg;

    // PC load source (PC_data_sel)
    localparam logic PC_ADD = 1'b0;   // PC + sign-extended offset
    localparam logic BASE_R = 1'b1;   // ALU result, normally PASS_A of a base register

    // PC adder offset (PC_add_sel)
    localparam logic PC_OFF11 = 1'b0; // sext(IR[10:0]), JSR
    localparam logic PC_OFF9  = 1'b1; // sext(IR[8:0]), BR/LD/ST/LDI/STI/LEA

    // Memory address source (addr_MEM_sel); 2'b11 falls back to PC
    localparam logic [1:0] PC_addr    = 2'b00;
    localparam logic [1:0] ALU_addr   = 2'b01;
    localparam logic [1:0] store_addr = 2'b10;

    // Register file write data (w_RF_sel); 2'b11 also selects the ALU
    localparam logic [1:0] PC_data  = 2'b00;
    localparam logic [1:0] MEM_data = 2'b01;
    localparam logic [1:0] ALU_data = 2'b10;

    // ALU operand selects
    localparam logic A_PC  = 1'b0;
    localparam logic A_RF  = 1'b1;
    localparam logic B_RF  = 1'b0;
    localparam logic B_IMM = 1'b1;

    // ALU operations (ALU_sel)
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_NOT  = 2'b11;

    // Condition-flag source (NZP_sel)
    localparam logic NZP_ALU = 1'b0;
    localparam logic NZP_MEM = 1'b1;

    // Immediate width (sext_sel); 2'b11 also selects the 9-bit form
    localparam logic [1:0] SEXT_5 = 2'b00;
    localparam logic [1:0] SEXT_6 = 2'b01;
    localparam logic [1:0] SEXT_9 = 2'b10;

    // LC3 opcodes, IR[15:12]
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // Condition codes of a 16-bit value, returned as {n, z, p}; exactly one bit is set.
    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        logic w_neg;
        logic w_zero;
        w_neg  = v[15];
        w_zero = (v == 16'h0000);
        return {w_neg, w_zero, ~w_neg & ~w_zero};
    endfunction

endpackage

// File: rtl/punc_regfile.sv
// 8-entry register file: three combinational read ports, one synchronous write port, synchronous clear.
// Latency: reads are combinational; a write is visible one cycle after its enable (same-cycle read sees old data).
// Backpressure: none; every write and clear strobe is accepted on the edge it is sampled.
//
// Ports: clk, rst (sync active-high), i_clr (sync clear of all entries, beats i_w_en),
//        i_w_en/i_w_addr/i_w_dat write port, i_r_addr_0/1/2 -> o_r_dat_0/1/2 read ports.
module punc_regfile #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_w_en,
    input  logic [2:0]    i_w_addr,
    input  logic [DW-1:0] i_w_dat,
    input  logic [2:0]    i_r_addr_0,
    input  logic [2:0]    i_r_addr_1,
    input  logic [2:0]    i_r_addr_2,
    output logic [DW-1:0] o_r_dat_0,
    output logic [DW-1:0] o_r_dat_1,
    output logic [DW-1:0] o_r_dat_2
);

    logic [DW-1:0] r_regs [0:7];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_w_en) begin
            r_regs[i_w_addr] <= i_w_dat;
        end
    end

    assign o_r_dat_0 = r_regs[i_r_addr_0];
    assign o_r_dat_1 = r_regs[i_r_addr_1];
    assign o_r_dat_2 = r_regs[i_r_addr_2];

endmodule

// File: rtl/punc_datapath.sv
// PUnC LC3 datapath: PC, IR, register file, NZP flags, indirect store register, ALU and muxes driven by controller strobes.
// Latency: every register update lands on the edge after its strobe; memory address/write data/write enable are combinational.
// Backpressure: none; the controller owns sequencing and memory reads are combinational.
//
// Ports: clk, rst (sync active-high); PC_* / IR_ld / store_ld / N_ld Z_ld P_ld load strobes;
//        *_sel mux selects; RF write/read/clear controls; mem_r_data in; mem_addr, mem_w_data, mem_w_en out;
//        ir and n/z/p back to the controller; pc_dbg and rf_dbg_data for observation.
module punc_datapath
    import punc_pkg::*;
#(
    parameter int            DW     = 16,
    parameter logic [DW-1:0] PC_RST = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PC_data_sel,
    input  logic          PC_add_sel,
    input  logic          PC_ld,
    input  logic          PC_clr,
    input  logic          PC_inc,
    input  logic          IR_ld,
    input  logic [1:0]    addr_MEM_sel,
    input  logic          w_en_MEM,
    input  logic [1:0]    w_RF_sel,
    input  logic [2:0]    w_addr_RF,
    input  logic          w_en_RF,
    input  logic          rst_RF,
    input  logic [2:0]    r_addr_0_RF,
    input  logic [2:0]    r_addr_1_RF,
    input  logic [2:0]    r_addr_2_RF,
    input  logic [1:0]    sext_sel,
    input  logic          A_sel,
    input  logic          B_sel,
    input  logic [1:0]    ALU_sel,
    input  logic          NZP_sel,
    input  logic          N_ld,
    input  logic          Z_ld,
    input  logic          P_ld,
    input  logic          store_ld,
    input  logic [DW-1:0] mem_r_data,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_w_data,
    output logic          mem_w_en,
    output logic [DW-1:0] ir,
    output logic          n,
    output logic          z,
    output logic          p,
    output logic [DW-1:0] pc_dbg,
    output logic [DW-1:0] rf_dbg_data
);

    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_store;
    logic          r_n;
    logic          r_z;
    logic          r_p;

    logic [DW-1:0] w_rf_r0;
    logic [DW-1:0] w_rf_r1;
    logic [DW-1:0] w_rf_wdat;
    logic [DW-1:0] w_imm;
    logic [DW-1:0] w_pc_off;
    logic [DW-1:0] w_pc_add;
    logic [DW-1:0] w_pc_ld_val;
    logic [DW-1:0] w_alu_a;
    logic [DW-1:0] w_alu_b;
    logic [DW-1:0] w_alu;
    logic [DW-1:0] w_nzp_src;
    logic [2:0]    w_nzp;

    // Sign-extended immediates and PC offsets taken straight from IR fields
    always_comb begin
        case (sext_sel)
            SEXT_5:  w_imm = {{(DW-5){r_ir[4]}}, r_ir[4:0]};
            SEXT_6:  w_imm = {{(DW-6){r_ir[5]}}, r_ir[5:0]};
            default: w_imm = {{(DW-9){r_ir[8]}}, r_ir[8:0]};
        endcase
    end

    assign w_pc_off = (PC_add_sel == PC_OFF9) ? {{(DW-9){r_ir[8]}},  r_ir[8:0]}
                                              : {{(DW-11){r_ir[10]}}, r_ir[10:0]};
    // The controller increments PC during fetch, so this adds to the already-advanced PC
    assign w_pc_add = r_pc + w_pc_off;

    // ALU
    assign w_alu_a = (A_sel == A_RF)  ? w_rf_r0 : r_pc;
    assign w_alu_b = (B_sel == B_IMM) ? w_imm   : w_rf_r1;

    always_comb begin
        case (ALU_sel)
            ALU_ADD:  w_alu = w_alu_a + w_alu_b;
            ALU_AND:  w_alu = w_alu_a & w_alu_b;
            ALU_PASS: w_alu = w_alu_a;
            default:  w_alu = ~w_alu_a;
        endcase
    end

    assign w_pc_ld_val = (PC_data_sel == BASE_R) ? w_alu : w_pc_add;

    // PC: clear beats load beats increment
    always_ff @(posedge clk) begin
        if (rst || PC_clr) begin
            r_pc <= PC_RST;
        end else if (PC_ld) begin
            r_pc <= w_pc_ld_val;
        end else if (PC_inc) begin
            r_pc <= r_pc + ONE;
        end
    end

    // IR and the LDI/STI indirect-address register both capture the current memory word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir    <= '0;
            r_store <= '0;
        end else begin
            if (IR_ld) begin
                r_ir <= mem_r_data;
            end
            if (store_ld) begin
                r_store <= mem_r_data;
            end
        end
    end

    // Flags load individually so the controller can update a subset
    assign w_nzp_src = (NZP_sel == NZP_MEM) ? mem_r_data : w_alu;
    assign w_nzp     = nzp_of(w_nzp_src);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_p <= 1'b0;
        end else begin
            if (N_ld) r_n <= w_nzp[2];
            if (Z_ld) r_z <= w_nzp[1];
            if (P_ld) r_p <= w_nzp[0];
        end
    end

    // RF write data: on JSR the pre-update PC goes to R7 on the same edge PC takes the target
    always_comb begin
        case (w_RF_sel)
            PC_data:  w_rf_wdat = r_pc;
            MEM_data: w_rf_wdat = mem_r_data;
            default:  w_rf_wdat = w_alu;
        endcase
    end

    punc_regfile #(
        .DW (DW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (rst_RF),
        .i_w_en     (w_en_RF),
        .i_w_addr   (w_addr_RF),
        .i_w_dat    (w_rf_wdat),
        .i_r_addr_0 (r_addr_0_RF),
        .i_r_addr_1 (r_addr_1_RF),
        .i_r_addr_2 (r_addr_2_RF),
        .o_r_dat_0  (w_rf_r0),
        .o_r_dat_1  (w_rf_r1),
        .o_r_dat_2  (rf_dbg_data)
    );

    // Memory interface
    always_comb begin
        case (addr_MEM_sel)
            ALU_addr:   mem_addr = w_alu;
            store_addr: mem_addr = r_store;
            default:    mem_addr = r_pc;
        endcase
    end

    assign mem_w_data = w_rf_r1;
    assign mem_w_en   = w_en_MEM;

    assign ir     = r_ir;
    assign n      = r_n;
    assign z      = r_z;
    assign p      = r_p;
    assign pc_dbg = r_pc;

endmodule

// File: tb/tb_punc_datapath.sv
// Directed bench for punc_datapath with a poke-only memory model and immediate-assertion checks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_punc_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_data_sel, PC_add_sel, PC_ld, PC_clr, PC_inc, IR_ld;
    logic [1:0]  addr_MEM_sel;
    logic        w_en_MEM;
    logic [1:0]  w_RF_sel;
    logic [2:0]  w_addr_RF;
    logic        w_en_RF, rst_RF;
    logic [2:0]  r_addr_0_RF, r_addr_1_RF, r_addr_2_RF;
    logic [1:0]  sext_sel;
    logic        A_sel, B_sel;
    logic [1:0]  ALU_sel;
    logic        NZP_sel, N_ld, Z_ld, P_ld, store_ld;
    logic [15:0] mem_r_data;
    logic [15:0] mem_addr, mem_w_data;
    logic        mem_w_en;
    logic [15:0] ir;
    logic        n, z, p;
    logic [15:0] pc_dbg, rf_dbg_data;

    logic [15:0] mem [0:65535];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_addr];

    punc_datapath #(.DW(16), .PC_RST(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .PC_data_sel(PC_data_sel), .PC_add_sel(PC_add_sel), .PC_ld(PC_ld), .PC_clr(PC_clr), .PC_inc(PC_inc),
        .IR_ld(IR_ld), .addr_MEM_sel(addr_MEM_sel), .w_en_MEM(w_en_MEM),
        .w_RF_sel(w_RF_sel), .w_addr_RF(w_addr_RF), .w_en_RF(w_en_RF), .rst_RF(rst_RF),
        .r_addr_0_RF(r_addr_0_RF), .r_addr_1_RF(r_addr_1_RF), .r_addr_2_RF(r_addr_2_RF),
        .sext_sel(sext_sel), .A_sel(A_sel), .B_sel(B_sel), .ALU_sel(ALU_sel),
        .NZP_sel(NZP_sel), .N_ld(N_ld), .Z_ld(Z_ld), .P_ld(P_ld), .store_ld(store_ld),
        .mem_r_data(mem_r_data), .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
        .ir(ir), .n(n), .z(z), .p(p), .pc_dbg(pc_dbg), .rf_dbg_data(rf_dbg_data)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        PC_data_sel = 1'b0; PC_add_sel = 1'b0; PC_ld = 1'b0; PC_clr = 1'b0; PC_inc = 1'b0;
        IR_ld = 1'b0; addr_MEM_sel = 2'b00; w_en_MEM = 1'b0;
        w_RF_sel = 2'b00; w_addr_RF = 3'd0; w_en_RF = 1'b0; rst_RF = 1'b0;
        r_addr_0_RF = 3'd0; r_addr_1_RF = 3'd0; r_addr_2_RF = 3'd0;
        sext_sel = 2'b00; A_sel = 1'b0; B_sel = 1'b0; ALU_sel = 2'b00;
        NZP_sel = 1'b0; N_ld = 1'b0; Z_ld = 1'b0; P_ld = 1'b0; store_ld = 1'b0;
    endtask

    // One clock edge with the currently driven strobes, then back to idle
    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic rf_read(input logic [2:0] r, output logic [15:0] v);
        r_addr_2_RF = r;
        #1;
        v = rf_dbg_data;
    endtask

    // Write a register through the memory-data path, using the word at the current PC
    task automatic load_reg(input logic [2:0] r, input logic [15:0] v);
        mem[pc_dbg] = v;
        w_RF_sel = 2'b01; w_addr_RF = r; w_en_RF = 1'b1;
        step();
    endtask

    // PC <= PASS_A(R6)
    task automatic set_pc(input logic [15:0] v);
        load_reg(3'd6, v);
        A_sel = 1'b1; r_addr_0_RF = 3'd6; ALU_sel = 2'b10; PC_data_sel = 1'b1; PC_ld = 1'b1;
        step();
    endtask

    task automatic check_all_rf_zero(input string tag);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            rf_read(3'(i), v);
            check($sformatf("%s_r%0d", tag, i), v, 16'h0000);
        end
    endtask

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        idle();

        // Reset beats PC_inc and an RF write
        rst = 1'b1; PC_inc = 1'b1; w_en_RF = 1'b1; w_addr_RF = 3'd3; w_RF_sel = 2'b10;
        step();
        check("rst_pc", pc_dbg, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_nzp", {13'b0, n, z, p}, 16'h0000);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check_all_rf_zero("rst");

        // ADD R3 = R1 + R2 = 5 + FFFA
        load_reg(3'd1, 16'h0005);
        load_reg(3'd2, 16'hFFFA);
        r_addr_0_RF = 3'd1; r_addr_1_RF = 3'd2; A_sel = 1'b1; B_sel = 1'b0; ALU_sel = 2'b00;
        w_RF_sel = 2'b10; w_addr_RF = 3'd3; w_en_RF = 1'b1; N_ld = 1'b1; Z_ld = 1'b1; P_ld = 1'b1;
        w_en_MEM = 1'b1;
        #1;
        check("mem_w_data_port1", mem_w_data, 16'hFFFA);
        check("mem_w_en_pass", {15'b0, mem_w_en}, 16'h0001);
        step();
        rf_read(3'd3, v);
        check("add_r3", v, 16'hFFFF);
        check("add_nzp", {13'b0, n, z, p}, 16'h0004);

        // AND R4 = 5 & FFFA = 0 -> z
        r_addr_0_RF = 3'd1; r_addr_1_RF = 3'd2; A_sel = 1'b1; ALU_sel = 2'b01;
        w_RF_sel = 2'b11; w_addr_RF = 3'd4; w_en_RF = 1'b1; N_ld = 1'b1; Z_ld = 1'b1; P_ld = 1'b1;
        step();
        rf_read(3'd4, v);
        check("and_r4", v, 16'h0000);
        check("and_nzp", {13'b0, n, z, p}, 16'h0002);

        // NOT R1 with only N_ld: n sets, z keeps its old 1
        r_addr_0_RF = 3'd1; A_sel = 1'b1; ALU_sel = 2'b11; w_RF_sel = 2'b10; w_addr_RF = 3'd5; w_en_RF = 1'b1;
        N_ld = 1'b1;
        step();
        rf_read(3'd5, v);
        check("not_r5", v, 16'hFFFA);
        check("not_partial_nzp", {13'b0, n, z, p}, 16'h0006);

        // Flags from memory data (positive)
        mem[pc_dbg] = 16'h0123;
        NZP_sel = 1'b1; N_ld = 1'b1; Z_ld = 1'b1; P_ld = 1'b1;
        step();
        check("mem_nzp", {13'b0, n, z, p}, 16'h0001);

        // PC-relative load: 3001 + sext(IR[8:0]=1FE) = 2FFF
        set_pc(16'h3001);
        check("pc_base_ld", pc_dbg, 16'h3001);
        mem[16'h3001] = 16'h0FFE;
        IR_ld = 1'b1;
        step();
        check("ir_ld", ir, 16'h0FFE);
        PC_ld = 1'b1; PC_add_sel = 1'b1; PC_data_sel = 1'b0;
        step();
        check("pc_off9", pc_dbg, 16'h2FFF);

        // ADD immediate: R1 + sext(IR[4:0]=11110) = 5 + FFFE = 3
        r_addr_0_RF = 3'd1; A_sel = 1'b1; B_sel = 1'b1; sext_sel = 2'b00; ALU_sel = 2'b00;
        w_RF_sel = 2'b10; w_addr_RF = 3'd4; w_en_RF = 1'b1;
        step();
        rf_read(3'd4, v);
        check("add_imm5", v, 16'h0003);

        // Increment wraps
        set_pc(16'hFFFF);
        PC_inc = 1'b1;
        step();
        check("pc_wrap", pc_dbg, 16'h0000);

        // JSR: R7 <= old PC while PC <= PC + sext(IR[10:0])
        load_reg(3'd7, 16'h1234);
        set_pc(16'h3005);
        mem[16'h3005] = 16'h4810;
        IR_ld = 1'b1;
        step();
        PC_ld = 1'b1; PC_data_sel = 1'b0; PC_add_sel = 1'b0;
        w_RF_sel = 2'b00; w_addr_RF = 3'd7; w_en_RF = 1'b1; r_addr_2_RF = 3'd7;
        #1;
        check("jsr_r7_old_read", rf_dbg_data, 16'h1234);
        step();
        rf_read(3'd7, v);
        check("jsr_r7", v, 16'h3005);
        check("jsr_pc", pc_dbg, 16'h3015);

        // LDI: store <= mem[3010] = 4000, then Rd <= mem[4000] = 0
        load_reg(3'd5, 16'h7777);
        load_reg(3'd6, 16'h3010);
        mem[16'h3010] = 16'h4000;
        mem[16'h4000] = 16'h0000;
        A_sel = 1'b1; r_addr_0_RF = 3'd6; ALU_sel = 2'b10; addr_MEM_sel = 2'b01; store_ld = 1'b1;
        #1;
        check("ldi1_addr", mem_addr, 16'h3010);
        step();
        addr_MEM_sel = 2'b10; w_RF_sel = 2'b01; w_addr_RF = 3'd5; w_en_RF = 1'b1;
        NZP_sel = 1'b1; N_ld = 1'b1; Z_ld = 1'b1; P_ld = 1'b1;
        #1;
        check("ldi2_addr", mem_addr, 16'h4000);
        step();
        rf_read(3'd5, v);
        check("ldi_rd", v, 16'h0000);
        check("ldi_nzp", {13'b0, n, z, p}, 16'h0002);

        // PC priority: clear > load > increment
        PC_clr = 1'b1; PC_ld = 1'b1; PC_inc = 1'b1; PC_data_sel = 1'b1;
        A_sel = 1'b1; r_addr_0_RF = 3'd6; ALU_sel = 2'b10;
        step();
        check("pc_clr_prio", pc_dbg, 16'h0000);
        PC_ld = 1'b1; PC_inc = 1'b1; PC_data_sel = 1'b1;
        A_sel = 1'b1; r_addr_0_RF = 3'd6; ALU_sel = 2'b10;
        step();
        check("pc_ld_prio", pc_dbg, 16'h3010);

        // rst_RF beats a same-cycle write
        mem[pc_dbg] = 16'hBEEF;
        rst_RF = 1'b1; w_en_RF = 1'b1; w_addr_RF = 3'd2; w_RF_sel = 2'b01;
        step();
        check_all_rf_zero("rst_rf");

        // Reset from a loaded state beats every strobe
        load_reg(3'd3, 16'hABCD);
        rst = 1'b1; PC_inc = 1'b1; w_en_RF = 1'b1; w_addr_RF = 3'd1; w_RF_sel = 2'b01;
        IR_ld = 1'b1; store_ld = 1'b1; N_ld = 1'b1; Z_ld = 1'b1; P_ld = 1'b1; NZP_sel = 1'b1;
        step();
        check("rst2_pc", pc_dbg, 16'h0000);
        check("rst2_ir", ir, 16'h0000);
        check("rst2_nzp", {13'b0, n, z, p}, 16'h0000);
        rf_read(3'd3, v);
        check("rst2_r3", v, 16'h0000);
        addr_MEM_sel = 2'b10;
        #1;
        check("rst2_store", mem_addr, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
